vec_lsu_sequencer: RTL and testbench

Multi-cycle sequencer that executes one decoded vector load or store element by element against a single-ported scalar memory interface. It sits between the vector controller/decoder and the memory port. It latches the operation at `start`, generates per-element addresses for unit-stride, constant-stride and indexed modes, and issues one memory request at a time. It writes loaded elements back to the vector register file and pulses `done` when `vl` elements have been transferred.

---
 rtl/vec_lsu_pkg.sv | 36 +++
 rtl/vec_lsu_lane_align.sv | 42 ++++
 rtl/vec_lsu_sequencer.sv | 167 ++++++++++++++++
 tb/tb_vec_lsu_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_lsu_pkg.sv
// Shared types and helpers for the vector load/store sequencer.
//   lsu_state_e : sequencer FSM states
//   lsu_mode_e  : address generation mode
//   sew_e       : element width encoding
//   sew_bytes() : element size in bytes
//   be_mask()   : unshifted byte-enable mask for an element
package vec_lsu_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} lsu_state_e;

  typedef enum logic [1:0] {ModeUnit, ModeStrided, ModeIndexed} lsu_mode_e;

  typedef enum logic [1:0] {
    Sew8    = 2'b00,
    Sew16   = 2'b01,
    Sew32   = 2'b10,
    SewRsvd = 2'b11
  } sew_e;

  function automatic logic [2:0] sew_bytes(sew_e s);
    case (s)
      Sew8:    return 3'd1;
      Sew16:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] be_mask(sew_e s);
    case (s)
      Sew8:    return 4'b0001;
      Sew16:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/vec_lsu_lane_align.sv
// Combinational byte-lane alignment for a 32-bit memory word.
//   sew_i     : element width
//   st_off_i  : byte offset of the current store/request address
//   st_data_i : store element (low SEW bits)
//   ld_off_i  : byte offset of the outstanding load
//   rdata_i   : word-aligned load data
//   wdata_o   : store data shifted into its byte lanes
//   be_o      : byte enables for the request
//   ld_elem_o : extracted, zero-extended load element
module vec_lsu_lane_align
  import vec_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      sew_i,
  input  logic [1:0]      st_off_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [1:0]      ld_off_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] wdata_o,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] ld_elem_o
);

  sew_e            sew;
  logic [XLEN-1:0] ld_shifted;

  assign sew        = sew_e'(sew_i);
  assign wdata_o    = st_data_i << {st_off_i, 3'b000};
  assign be_o       = be_mask(sew) << st_off_i;
  assign ld_shifted = rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_elem_o = '0;
    case (sew)
      Sew8:    ld_elem_o[7:0]  = ld_shifted[7:0];
      Sew16:   ld_elem_o[15:0] = ld_shifted[15:0];
      default: ld_elem_o       = ld_shifted;
    endcase
  end

endmodule

// File: rtl/vec_lsu_sequencer.sv
// Executes one vector load/store element by element over a single scalar memory port.
//   clk, reset (sync, active-low)
//   start/ld_inst/st_inst/stride_sel/index_str/base_addr/stride/vl/sew : operation to latch
//   elem_idx -> VRF, idx_data/st_data <- VRF (combinational reads)
//   mem_req_* / mem_rsp_* : scalar memory port, one outstanding request
//   vrf_wr_en/vrf_wr_data : load writeback
//   busy/done/err         : status
module vec_lsu_sequencer
  import vec_lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned VL_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ld_inst,
  input  logic            st_inst,
  input  logic            stride_sel,
  input  logic            index_str,
  input  logic [XLEN-1:0] base_addr,
  input  logic [XLEN-1:0] stride,
  input  logic [VL_W-1:0] vl,
  input  logic [1:0]      sew,
  output logic [VL_W-1:0] elem_idx,
  input  logic [XLEN-1:0] idx_data,
  input  logic [XLEN-1:0] st_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            vrf_wr_en,
  output logic [XLEN-1:0] vrf_wr_data,
  output logic            busy,
  output logic            done,
  output logic            err
);

  lsu_state_e      state_q;
  lsu_mode_e       mode_q;
  sew_e            sew_q;
  logic            we_q;
  logic            err_q;
  logic [XLEN-1:0] base_q;
  logic [XLEN-1:0] stride_q;
  logic [XLEN-1:0] offset_q;
  logic [VL_W-1:0] vl_q;
  logic [VL_W-1:0] elem_idx_q;
  logic [1:0]      ld_off_q;

  logic            cfg_legal;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] step;
  logic            aligned;
  logic            last;
  logic            req_valid;
  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_ld_elem;

  assign cfg_legal = (ld_inst ^ st_inst) && (sew != 2'b11);
  assign addr      = base_q + ((mode_q == ModeIndexed) ? idx_data : offset_q);
  // Offset accumulates by addition only, so no multiplier for i*stride.
  assign step      = (mode_q == ModeUnit) ? XLEN'(sew_bytes(sew_q)) : stride_q;
  assign last      = (elem_idx_q == vl_q - VL_W'(1));
  assign req_valid = (state_q == StReq) && aligned;

  always_comb begin
    case (sew_q)
      Sew8:    aligned = 1'b1;
      Sew16:   aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  vec_lsu_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .sew_i     (sew_q),
    .st_off_i  (addr[1:0]),
    .st_data_i (st_data),
    .ld_off_i  (ld_off_q),
    .rdata_i   (mem_rdata),
    .wdata_o   (al_wdata),
    .be_o      (al_be),
    .ld_elem_o (al_ld_elem)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      mode_q     <= ModeUnit;
      sew_q      <= Sew8;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      base_q     <= '0;
      stride_q   <= '0;
      offset_q   <= '0;
      vl_q       <= '0;
      elem_idx_q <= '0;
      ld_off_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && cfg_legal) begin
            we_q       <= st_inst;
            mode_q     <= index_str ? ModeIndexed : (stride_sel ? ModeUnit : ModeStrided);
            sew_q      <= sew_e'(sew);
            base_q     <= base_addr;
            stride_q   <= stride;
            vl_q       <= vl;
            elem_idx_q <= '0;
            offset_q   <= '0;
            err_q      <= 1'b0;
            state_q    <= (vl == '0) ? StDone : StReq;
          end
        end
        StReq: begin
          if (!aligned) begin
            err_q   <= 1'b1;
            state_q <= StDone;
          end else if (mem_req_ready) begin
            ld_off_q <= addr[1:0];
            if (!we_q) begin
              state_q <= StResp;
            end else if (last) begin
              state_q <= StDone;
            end else begin
              elem_idx_q <= elem_idx_q + VL_W'(1);
              offset_q   <= offset_q + step;
            end
          end
        end
        StResp: begin
          if (mem_rsp_valid) begin
            if (last) begin
              state_q <= StDone;
            end else begin
              elem_idx_q <= elem_idx_q + VL_W'(1);
              offset_q   <= offset_q + step;
              state_q    <= StReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Request fields are gated so the port is quiet outside an issued request.
  assign mem_req_valid = req_valid;
  assign mem_addr      = req_valid ? addr : '0;
  assign mem_we        = req_valid & we_q;
  assign mem_wdata     = (req_valid && we_q) ? al_wdata : '0;
  assign mem_be        = req_valid ? al_be : 4'b0000;
  assign vrf_wr_en     = (state_q == StResp) && mem_rsp_valid;
  assign vrf_wr_data   = vrf_wr_en ? al_ld_elem : '0;
  assign elem_idx      = elem_idx_q;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign err           = err_q;

endmodule

// File: tb/tb_vec_lsu_sequencer.sv
module tb_vec_lsu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, ld_inst, st_inst, stride_sel, index_str;
  logic [31:0] base_addr, stride;
  logic [8:0]  vl;
  logic [1:0]  sew;
  logic [8:0]  elem_idx;
  logic [31:0] idx_data, st_data;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        vrf_wr_en;
  logic [31:0] vrf_wr_data;
  logic        busy, done, err;

  vec_lsu_sequencer #(.XLEN(32), .VL_W(9)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ld_inst       (ld_inst),
    .st_inst       (st_inst),
    .stride_sel    (stride_sel),
    .index_str     (index_str),
    .base_addr     (base_addr),
    .stride        (stride),
    .vl            (vl),
    .sew           (sew),
    .elem_idx      (elem_idx),
    .idx_data      (idx_data),
    .st_data       (st_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .vrf_wr_en     (vrf_wr_en),
    .vrf_wr_data   (vrf_wr_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_vrf[$];
  logic [31:0] idx_tab[16];
  logic [31:0] st_tab[16];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int ready_hold = 0;
  bit rsp_block = 0;
  bit rsp_force = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // VRF model: combinational reads at elem_idx.
  always_comb begin
    idx_data = idx_tab[elem_idx[3:0]];
    st_data  = st_tab[elem_idx[3:0]];
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[17:2], ~a[17:2]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] be_bytes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder and scoreboard monitor: samples at negedge, drives just after posedge.
  initial begin : responder
    bit          hs_load;
    bit          stall_q;
    logic [31:0] rsp_addr, s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_we;
    req_t        e;
    logic [31:0] ev;
    stall_q = 0;
    rsp_addr = '0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      hs_load = 0;
      if (stall_q) begin
        check_eq("stall_valid", {31'b0, mem_req_valid}, 32'd1);
        check_eq("stall_addr", mem_addr, s_addr);
        check_eq("stall_be", {28'b0, mem_be}, {28'b0, s_be});
        check_eq("stall_we", {31'b0, mem_we}, {31'b0, s_we});
        check_eq("stall_wdata", mem_wdata, s_wdata);
      end
      if (mem_req_valid && mem_req_ready) begin
        hs_cnt++;
        check_eq("req_expected", {31'b0, exp_req.size() > 0}, 32'd1);
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front();
          check_eq("req_addr", mem_addr, e.addr);
          check_eq("req_we", {31'b0, mem_we}, {31'b0, e.we});
          check_eq("req_be", {28'b0, mem_be}, {28'b0, e.be});
          if (e.we) check_eq("req_wdata", mem_wdata & be_bytes(e.be), e.wdata & be_bytes(e.be));
        end
        if (!mem_we) begin
          hs_load = 1;
          rsp_addr = mem_addr;
        end
      end
      if (vrf_wr_en) begin
        check_eq("vrf_expected", {31'b0, exp_vrf.size() > 0}, 32'd1);
        if (exp_vrf.size() > 0) begin
          ev = exp_vrf.pop_front();
          check_eq("vrf_data", vrf_wr_data, ev);
        end
      end
      if (done) done_cnt++;
      stall_q = mem_req_valid && !mem_req_ready;
      s_addr = mem_addr; s_be = mem_be; s_we = mem_we; s_wdata = mem_wdata;
      @(posedge clk);
      #1;
      mem_rsp_valid = (hs_load && !rsp_block) || rsp_force;
      mem_rdata = hs_load ? mem_word(rsp_addr) : 32'hDEAD_BEEF;
      if (ready_hold > 0) begin
        mem_req_ready = 1'b0;
        ready_hold--;
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  task automatic run_op(input string tag, input logic ld, input logic unit, input logic idx,
                        input logic [31:0] base, input logic [31:0] strd, input int n,
                        input logic [1:0] sw, input int exp_lat, input bit poke);
    logic [31:0] off, a, size, emask;
    logic [3:0]  be;
    logic [1:0]  lo;
    bit          exp_err, seen;
    int          start_cyc, dc0, hs0, n_req;
    req_t        r;
    size    = 32'd1 << sw;
    emask   = (sw == 2'b00) ? 32'hFF : (sw == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
    off     = '0;
    exp_err = 0;
    n_req   = 0;
    for (int i = 0; i < n; i++) begin
      a = base + (idx ? idx_tab[i] : off);
      off = off + (unit ? size : strd);
      if ((a % size) != 0) begin
        exp_err = 1;
        break;
      end
      lo = a[1:0];
      be = ((4'b0001 << size) - 4'b0001) << lo;
      r.addr = a; r.we = !ld; r.be = be; r.wdata = st_tab[i] << (8 * lo);
      exp_req.push_back(r);
      n_req++;
      if (ld) exp_vrf.push_back((mem_word(a) >> (8 * lo)) & emask);
    end
    dc0 = done_cnt;
    hs0 = hs_cnt;
    @(negedge clk);
    start = 1; ld_inst = ld; st_inst = !ld; stride_sel = unit; index_str = idx;
    base_addr = base; stride = strd; vl = 9'(n); sew = sw;
    start_cyc = cyc;
    @(negedge clk);
    start = 0;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (poke && k == 1) begin
        start = 1; ld_inst = 1; st_inst = 0; stride_sel = 1; index_str = 0;
        base_addr = 32'h900; vl = 9'd5; sew = 2'b00;
      end
      @(negedge clk);
      start = 0;
    end
    check_eq({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      check_eq({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
      if (exp_lat > 0) check_eq({tag, "_latency"}, cyc - start_cyc, exp_lat);
    end
    @(negedge clk);
    @(negedge clk);
    check_eq({tag, "_done_once"}, done_cnt - dc0, 32'd1);
    check_eq({tag, "_handshakes"}, hs_cnt - hs0, n_req);
    check_eq({tag, "_req_left"}, exp_req.size(), 32'd0);
    check_eq({tag, "_vrf_left"}, exp_vrf.size(), 32'd0);
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
    exp_req.delete();
    exp_vrf.delete();
  endtask

  initial begin : main
    bit got_req;
    reset = 0; start = 0; ld_inst = 0; st_inst = 0; stride_sel = 0; index_str = 0;
    base_addr = '0; stride = '0; vl = '0; sew = '0;
    for (int i = 0; i < 16; i++) begin
      idx_tab[i] = 32'h4 * i;
      st_tab[i]  = 32'hA5C3_0000 + 32'h0101 * i + 32'h11;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_err", {31'b0, err}, 32'd0);
    check_eq("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check_eq("rst_elem_idx", {23'b0, elem_idx}, 32'd0);
    reset = 1;
    @(negedge clk);
    check_eq("post_rst_vrf_wr_en", {31'b0, vrf_wr_en}, 32'd0);

    run_op("unit_ld", 1, 1, 0, 32'h100, 32'h0, 4, 2'b01, 0, 0);
    run_op("str_st", 0, 0, 0, 32'h200, 32'hFFFF_FFF8, 3, 2'b10, 4, 0);
    idx_tab[0] = 32'h10; idx_tab[1] = 32'h3; idx_tab[2] = 32'h0;
    run_op("idx_ld", 1, 0, 1, 32'h300, 32'h0, 3, 2'b00, 0, 0);
    ready_hold = 5;
    run_op("bp_st", 0, 1, 0, 32'h500, 32'h0, 2, 2'b10, 0, 1);
    run_op("misalign", 0, 1, 0, 32'h102, 32'h0, 3, 2'b10, 2, 0);
    run_op("vl0", 1, 1, 0, 32'h700, 32'h0, 0, 2'b00, 1, 0);
    run_op("idx_st", 0, 0, 1, 32'h800, 32'h0, 3, 2'b00, 4, 0);

    // Abort a load in RESP, then feed a late response.
    rsp_block = 1;
    exp_req.push_back('{addr: 32'h400, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    @(negedge clk);
    start = 1; ld_inst = 1; st_inst = 0; stride_sel = 1; index_str = 0;
    base_addr = 32'h400; vl = 9'd2; sew = 2'b10;
    @(negedge clk);
    start = 0;
    got_req = 0;
    for (int k = 0; k < 20; k++) begin
      if (mem_req_valid) begin
        got_req = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("rst_test_req", {31'b0, got_req}, 32'd1);
    @(negedge clk);
    check_eq("rst_test_in_resp", {31'b0, busy && !mem_req_valid}, 32'd1);
    reset = 0;
    @(negedge clk);
    reset = 1;
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_done", {31'b0, done}, 32'd0);
    rsp_block = 0;
    rsp_force = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("late_rsp_vrf_wr_en", {31'b0, vrf_wr_en}, 32'd0);
      check_eq("late_rsp_busy", {31'b0, busy}, 32'd0);
    end
    rsp_force = 0;
    exp_req.delete();
    exp_vrf.delete();
    @(negedge clk);

    run_op("recover_ld", 1, 1, 0, 32'h601, 32'h0, 3, 2'b00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
